handle_factory: RTL and testbench

//  Hardware object factory: allocates unique object handles (IDs) from a fixed pool to
//  NUM_CH requesting channels, tags each handle with a product kind, recycles freed handles.

---
 rtl/handle_factory_pkg.sv | 25 ++
 rtl/handle_factory_rr_arbiter.sv | 30 +++
 rtl/handle_factory.sv | 154 +++++++++++++++
 tb/tb_handle_factory.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/handle_factory_pkg.sv
// handle_factory_pkg: shared widths, default-sized handle/kind types and error codes
// for the handle factory. Optional statistics are enabled by HANDLE_FACTORY_STATS_EN.
package handle_factory_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_KIND_W = 2;

    // Handle index width; a pool of one still needs a 1-bit index.
    function automatic int id_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Channel index width; a single channel still needs a 1-bit index.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    typedef logic [id_w(DEF_DEPTH)-1:0] id_t;
    typedef logic [DEF_KIND_W-1:0]      kind_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_DBL_FREE = 2'd1;

endpackage

// File: rtl/handle_factory_rr_arbiter.sv
// handle_factory_rr_arbiter: combinational round-robin arbiter. Grants the lowest
// requesting channel at or above ptr, wrapping around; grant is one-hot or zero.
module handle_factory_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt
);

    int              idx_s;
    logic            found_s;
    logic [CH_W-1:0] sel_s;

    // Scan channels starting at ptr; first requester found takes the grant.
    always_comb begin
        gnt     = {NUM_CH{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        sel_s   = {CH_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            idx_s      = (int'(ptr) + k) % NUM_CH;
            sel_s      = CH_W'(idx_s);
            gnt[sel_s] = gnt[sel_s] | (req[sel_s] & ~found_s);
            found_s    = found_s | req[sel_s];
        end
    end

endmodule

// File: rtl/handle_factory.sv
// handle_factory: allocates unique handles from a DEPTH-entry free FIFO to NUM_CH
// round-robin channels, tags each live handle with a kind, and recycles freed handles.
// Define HANDLE_FACTORY_STATS_EN to add stat_allocs / stat_peak outputs.
module handle_factory
    import handle_factory_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int KIND_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*KIND_W-1:0]   req_kind,
    output logic [NUM_CH-1:0]          req_ready,
    output logic                       gnt_valid,
    output logic [ch_w(NUM_CH)-1:0]    gnt_ch,
    output logic [id_w(DEPTH)-1:0]     gnt_id,
    output logic [KIND_W-1:0]          gnt_kind,
    input  logic                       free_valid,
    input  logic [id_w(DEPTH)-1:0]     free_id,
    output logic                       err_dbl_free,
    output logic [id_w(DEPTH):0]       count,
`ifdef HANDLE_FACTORY_STATS_EN
    output logic [31:0]                stat_allocs,
    output logic [id_w(DEPTH):0]       stat_peak,
`endif
    output logic                       empty
);

    localparam int ID_W = id_w(DEPTH);
    localparam int CH_W = ch_w(NUM_CH);

    logic [ID_W-1:0]   fifo_r [DEPTH];
    logic [KIND_W-1:0] kind_r [DEPTH];
    logic [DEPTH-1:0]  live_r;
    logic [ID_W-1:0]   rd_ptr_r;
    logic [ID_W-1:0]   wr_ptr_r;
    logic [ID_W:0]     count_r;
    logic [CH_W-1:0]   rr_ptr_r;

    logic [NUM_CH-1:0] arb_gnt_s;
    logic              alloc_s;
    logic              free_ok_s;
    logic [CH_W-1:0]   winner_s;
    logic [CH_W-1:0]   rr_next_s;
    logic [KIND_W-1:0] win_kind_s;
    logic [ID_W-1:0]   head_id_s;
    logic [ID_W:0]     count_next_s;
    logic [1:0]        err_code_s;

    handle_factory_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_r),
        .gnt (arb_gnt_s)
    );

    assign empty     = (count_r == {(ID_W+1){1'b0}});
    assign count     = count_r;
    assign head_id_s = fifo_r[rd_ptr_r];
    // Kind table lookup; the entry only changes when gnt_id itself is reissued.
    assign gnt_kind  = kind_r[gnt_id];

    // Grant gating, winner encoding and next-state arithmetic.
    always_comb begin
        req_ready  = empty ? {NUM_CH{1'b0}} : arb_gnt_s;
        alloc_s    = |req_ready;
        winner_s   = {CH_W{1'b0}};
        win_kind_s = {KIND_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            winner_s   = winner_s   | (req_ready[i] ? CH_W'(i) : {CH_W{1'b0}});
            win_kind_s = win_kind_s | (req_ready[i] ? req_kind[i*KIND_W +: KIND_W]
                                                    : {KIND_W{1'b0}});
        end
        if (winner_s == CH_W'(NUM_CH - 1)) begin
            rr_next_s = {CH_W{1'b0}};
        end else begin
            rr_next_s = winner_s + {{(CH_W-1){1'b0}}, 1'b1};
        end
        // A handle allocated this cycle is not live yet, so freeing it is an error.
        free_ok_s    = free_valid & live_r[free_id];
        err_code_s   = (free_valid && !live_r[free_id]) ? ERR_DBL_FREE : ERR_NONE;
        count_next_s = count_r - {{ID_W{1'b0}}, alloc_s} + {{ID_W{1'b0}}, free_ok_s};
    end

    // Pool state: free FIFO, live bitmap, kind table, pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= ID_W'(i);
                kind_r[i] <= {KIND_W{1'b0}};
            end
            live_r   <= {DEPTH{1'b0}};
            rd_ptr_r <= {ID_W{1'b0}};
            wr_ptr_r <= {ID_W{1'b0}};
            count_r  <= (ID_W+1)'(DEPTH);
            rr_ptr_r <= {CH_W{1'b0}};
        end else begin
            if (alloc_s) begin
                live_r[head_id_s] <= 1'b1;
                kind_r[head_id_s] <= win_kind_s;
                rd_ptr_r          <= rd_ptr_r + {{(ID_W-1){1'b0}}, 1'b1};
                rr_ptr_r          <= rr_next_s;
            end
            if (free_ok_s) begin
                live_r[free_id]  <= 1'b0;
                fifo_r[wr_ptr_r] <= free_id;
                wr_ptr_r         <= wr_ptr_r + {{(ID_W-1){1'b0}}, 1'b1};
            end
            count_r <= count_next_s;
        end
    end

    // Registered grant report and double-free pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_valid    <= 1'b0;
            gnt_ch       <= {CH_W{1'b0}};
            gnt_id       <= {ID_W{1'b0}};
            err_dbl_free <= 1'b0;
        end else begin
            gnt_valid    <= alloc_s;
            if (alloc_s) begin
                gnt_ch <= winner_s;
                gnt_id <= head_id_s;
            end
            err_dbl_free <= (err_code_s == ERR_DBL_FREE);
        end
    end

`ifdef HANDLE_FACTORY_STATS_EN
    logic [ID_W:0] live_next_s;
    assign live_next_s = (ID_W+1)'(DEPTH) - count_next_s;

    // Saturating grant counter and high-water mark of live handles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_allocs <= 32'd0;
            stat_peak   <= {(ID_W+1){1'b0}};
        end else begin
            if (alloc_s && (stat_allocs != 32'hFFFF_FFFF)) begin
                stat_allocs <= stat_allocs + 32'd1;
            end
            if (live_next_s > stat_peak) begin
                stat_peak <= live_next_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_handle_factory.sv
// tb_handle_factory: randomized and directed stimulus against a queue-based pool model.
module tb_handle_factory;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_valid = 4'd0;
    logic [7:0] req_kind = 8'd0;
    logic [3:0] req_ready;
    logic       gnt_valid;
    logic [1:0] gnt_ch;
    logic [3:0] gnt_id;
    logic [1:0] gnt_kind;
    logic       free_valid = 1'b0;
    logic [3:0] free_id = 4'd0;
    logic       err_dbl_free;
    logic [4:0] count;
    logic       empty;
`ifdef HANDLE_FACTORY_STATS_EN
    logic [31:0] stat_allocs;
    logic [4:0]  stat_peak;
`endif

    handle_factory #(.NUM_CH(4), .DEPTH(16), .KIND_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_kind     (req_kind),
        .req_ready    (req_ready),
        .gnt_valid    (gnt_valid),
        .gnt_ch       (gnt_ch),
        .gnt_id       (gnt_id),
        .gnt_kind     (gnt_kind),
        .free_valid   (free_valid),
        .free_id      (free_id),
        .err_dbl_free (err_dbl_free),
        .count        (count),
`ifdef HANDLE_FACTORY_STATS_EN
        .stat_allocs  (stat_allocs),
        .stat_peak    (stat_peak),
`endif
        .empty        (empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: free handles as an ordered queue, per-handle live/kind arrays.
    int q[$];
    bit live_m[16];
    int kind_m[16];
    int rrp;
    int exp_gv, exp_ch, exp_id, exp_kind, exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 16; i++) begin
            q.push_back(i);
            live_m[i] = 1'b0;
            kind_m[i] = 0;
        end
        rrp = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'd0;
        free_valid = 1'b0;
        #1;
        check("rst_gnt_valid", {31'd0, gnt_valid}, 32'd0);
        check("rst_err", {31'd0, err_dbl_free}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd16);
        check("rst_empty", {31'd0, empty}, 32'd0);
        check("rst_gnt_id", {28'd0, gnt_id}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic [3:0] rv, input logic [7:0] rk,
                        input logic fv, input logic [3:0] fid);
        int win;
        int id;
        @(negedge clk);
        req_valid = rv;
        req_kind = rk;
        free_valid = fv;
        free_id = fid;
        #1;
        win = -1;
        if (q.size() > 0) begin
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && rv[(rrp + k) % 4]) win = (rrp + k) % 4;
            end
        end
        check("req_ready", {28'd0, req_ready}, (win >= 0) ? (32'd1 << win) : 32'd0);
        exp_err = (fv && !live_m[fid]) ? 1 : 0;
        if (win >= 0) begin
            id = q.pop_front();
            live_m[id] = 1'b1;
            kind_m[id] = (rk >> (2 * win)) & 3;
            exp_gv = 1;
            exp_ch = win;
            exp_id = id;
            exp_kind = kind_m[id];
            rrp = (win + 1) % 4;
        end else begin
            exp_gv = 0;
        end
        if (fv && exp_err == 0) begin
            live_m[fid] = 1'b0;
            q.push_back(int'(fid));
        end
        @(posedge clk);
        #1;
        check("gnt_valid", {31'd0, gnt_valid}, exp_gv);
        if (exp_gv != 0) begin
            check("gnt_ch", {30'd0, gnt_ch}, exp_ch);
            check("gnt_id", {28'd0, gnt_id}, exp_id);
            check("gnt_kind", {30'd0, gnt_kind}, exp_kind);
        end
        check("err_dbl_free", {31'd0, err_dbl_free}, exp_err);
        check("count", {27'd0, count}, q.size());
        check("empty", {31'd0, empty}, (q.size() == 0) ? 32'd1 : 32'd0);
    endtask

    function automatic logic [3:0] pick_live();
        int ids[$];
        for (int i = 0; i < 16; i++) if (live_m[i]) ids.push_back(i);
        if (ids.size() == 0) return 4'($urandom_range(15, 0));
        return 4'(ids[$urandom_range(ids.size() - 1, 0)]);
    endfunction

    initial begin
        model_reset();
        #12;
        do_reset();

        // Drain the pool from channel 0 with kind 1, then one more request while empty.
        for (int i = 0; i < 16; i++) step(4'b0001, 8'h55, 1'b0, 4'd0);
        step(4'b0001, 8'h55, 1'b0, 4'd0);

        // Free handle 5 while empty with request held; grant follows a cycle later.
        step(4'b0001, 8'h02, 1'b1, 4'd5);
        step(4'b0001, 8'h02, 1'b0, 4'd0);

        // Double free of handle 3, then confirm the pulse drops.
        step(4'b0000, 8'h00, 1'b1, 4'd3);
        step(4'b0000, 8'h00, 1'b1, 4'd3);
        step(4'b0000, 8'h00, 1'b0, 4'd0);

        // All channels requesting: rotation 0,1,2,3,...
        do_reset();
        for (int i = 0; i < 8; i++) step(4'hF, 8'($urandom), 1'b0, 4'd0);

        // Same-cycle allocate and free at count 8; freed handle queues behind the rest.
        step(4'h1, 8'h03, 1'b1, 4'd2);
        for (int i = 0; i < 9; i++) step(4'h1, 8'($urandom), 1'b0, 4'd0);

        // Free of the handle being allocated in the same cycle is rejected.
        do_reset();
        step(4'h2, 8'h08, 1'b1, 4'd0);

        // Reset in the middle of a burst, then the next grant must be handle 0.
        for (int i = 0; i < 5; i++) step(4'hF, 8'($urandom), 1'b0, 4'd0);
        do_reset();
        step(4'h4, 8'h30, 1'b0, 4'd0);

        // Randomized traffic: mostly frees of live handles, some bogus frees.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] fid;
            logic fv;
            fv = ($urandom_range(1, 0) == 1);
            fid = ($urandom_range(3, 0) != 0) ? pick_live() : 4'($urandom_range(15, 0));
            step(4'($urandom), 8'($urandom), fv, fid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
